sram_access_ctrl: RTL

Access sequencer that sits between the digital request side and the `ROWS`×`COLS` real-valued SRAM cell array. It drives the array's write/read wordlines and write bitlines as VDD/VSS real levels, sequences setup, access, sense and recovery phases, and converts the array's real read bitlines back into a digital word. A valid/ready handshake on both the request and response sides lets the block absorb back-pressure.

---
 rtl/sram_access_ctrl_if.sv | 28 ++
 rtl/sram_access_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl_if.sv
// Request/response handshake bundle for sram_access_ctrl.
// Latency: none (wires only). Backpressure: req_ready / rsp_ready valid-ready pairs.
// Ports: master drives req_* and rsp_ready; slave drives req_ready and rsp_*.
interface sram_access_ctrl_if #(
  parameter int AW   = 4,
  parameter int COLS = 8
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_we;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Access sequencer between a valid/ready request port and a real-valued SRAM array.
// Latency: write response after WL_CYCLES+2 edges, read after WL_CYCLES+3 edges from accept.
// Backpressure: one op in flight; req_ready only in IDLE, response held while rsp_ready is low.
// Ports: clk/rst; bus (slave modport: req_*, rsp_*); row_wr/row_rd wordlines,
//        bl_wr/blb_wr write bitlines (real outputs); bl_rd/blb_rd read bitlines (real inputs).
module sram_access_ctrl #(
  parameter int  ROWS      = 16,
  parameter int  COLS      = 8,
  parameter int  WL_CYCLES = 2,
  parameter real VDD       = 1.5,
  parameter real VSS       = 0.0,
  parameter real VTH       = 0.8,
  localparam int AW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_access_ctrl_if.slave  bus,
  output real                row_wr [ROWS],
  output real                row_rd [ROWS],
  output real                bl_wr  [COLS],
  output real                blb_wr [COLS],
  input  real                bl_rd  [COLS],
  input  real                blb_rd [COLS]
);

  localparam int CW = (WL_CYCLES > 1) ? $clog2(WL_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, SENSE, RECOVER, RESP} state_t;

  state_t          state;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [COLS-1:0] wdata_q;
  logic [COLS-1:0] rdata_q;
  logic            err_q;
  logic [CW-1:0]   cnt;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_we_q;
  logic [COLS-1:0] rsp_rdata_q;
  logic            rsp_err_q;

  logic            oor;
  logic [COLS-1:0] sense_bits;
  logic            sense_amb;

  assign oor = int'(addr_q) >= ROWS;

  // A bit is only trusted when exactly one side of the pair is above threshold.
  always_comb begin
    sense_bits = '0;
    sense_amb  = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (bl_rd[c] > VTH && !(blb_rd[c] > VTH)) begin
        sense_bits[c] = 1'b1;
      end else if (blb_rd[c] > VTH && !(bl_rd[c] > VTH)) begin
        sense_bits[c] = 1'b0;
      end else begin
        sense_amb = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (oor) err_q <= 1'b1;
          cnt   <= CW'(WL_CYCLES - 1);
          state <= ACCESS;
        end
        ACCESS: begin
          if (cnt == '0) state <= we_q ? RECOVER : SENSE;
          else           cnt   <= cnt - CW'(1);
        end
        SENSE: begin
          rdata_q <= oor ? '0 : sense_bits;
          if (sense_amb) err_q <= 1'b1;
          state <= RECOVER;
        end
        RECOVER: begin
          rsp_valid_q <= 1'b1;
          rsp_we_q    <= we_q;
          rsp_rdata_q <= we_q ? '0 : rdata_q;
          rsp_err_q   <= err_q;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Levels decode straight from registered state so reset releases the array
  // immediately. An errored access (out-of-range row) never raises a wordline.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_wr[r] = VSS;
      row_rd[r] = VSS;
      if (!err_q && r == int'(addr_q)) begin
        if (state == ACCESS && we_q) row_wr[r] = VDD;
        if ((state == ACCESS || state == SENSE) && !we_q) row_rd[r] = VDD;
      end
    end
  end

  // Write data sits on the bitlines from SETUP through ACCESS; otherwise precharge.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      bl_wr[c]  = VDD;
      blb_wr[c] = VDD;
      if ((state == SETUP || state == ACCESS) && we_q) begin
        bl_wr[c]  = wdata_q[c] ? VDD : VSS;
        blb_wr[c] = wdata_q[c] ? VSS : VDD;
      end
    end
  end

endmodule
